// File: rtl/demux_1to2_buf_pkg.sv
// Shared constants and types for the buffered 1-to-2 demultiplexer.
// CYCLE is the nominal clock period used by the bench.
package demux_1to2_buf_pkg;

  localparam int CYCLE          = 10;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 2;
  localparam int STATS_WIDTH    = 16;

  // sel polarity matches mux_2to1: 0 steers to port 1, 1 steers to port 2
  typedef enum logic {
    PORT1 = 1'b0,
    PORT2 = 1'b1
  } port_e;

  function automatic logic [STATS_WIDTH-1:0] sat_inc(input logic [STATS_WIDTH-1:0] value);
    if (value == {STATS_WIDTH{1'b1}}) begin
      sat_inc = value;
    end else begin
      sat_inc = value + STATS_WIDTH'(1);
    end
  endfunction

endpackage

// File: rtl/demux_1to2_buf_fifo.sv
// Synchronous FIFO used once per demux output; head is a registered copy of
// the oldest entry and holds its last value once the FIFO drains.
module demux_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W-1:0]      rd_next_s;
  logic [CNT_W-1:0]      count_r;
  logic [DATA_WIDTH-1:0] head_r;
  logic [DATA_WIDTH-1:0] head_next_s;
  logic                  do_push_s;
  logic                  do_pop_s;

  // Status flags, qualified push/pop and the next value of the head register.
  always_comb begin
    full        = (count_r == CNT_W'(FIFO_DEPTH));
    empty       = (count_r == {CNT_W{1'b0}});
    do_push_s   = push & ~full;
    do_pop_s    = pop & ~empty;
    rd_next_s   = rd_ptr_r + PTR_W'(1);
    head_next_s = head_r;
    if (do_pop_s) begin
      // With a single entry left the only possible successor is the beat arriving now
      if (count_r > CNT_W'(1)) begin
        head_next_s = mem_r[rd_next_s];
      end else if (do_push_s) begin
        head_next_s = din;
      end else begin
        head_next_s = head_r;
      end
    end else if (empty && do_push_s) begin
      head_next_s = din;
    end else begin
      head_next_s = head_r;
    end
  end

  // Storage, pointers, occupancy and head register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      head_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_next_s;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      head_r <= head_next_s;
    end
  end

  assign head = head_r;

endmodule

// File: rtl/demux_1to2_buf.sv
// Buffered 1-to-2 demultiplexer: sel steers each accepted beat into one of two FIFOs.
// Optional DEMUX_STATS_EN adds pop counters per output and a saturating stall counter.
module demux_1to2_buf
  import demux_1to2_buf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   sel,
  input  logic [DATA_WIDTH-1:0]  din,
  output logic                   out1_valid,
  input  logic                   out1_ready,
  output logic [DATA_WIDTH-1:0]  dout1,
  output logic                   out2_valid,
  input  logic                   out2_ready,
  output logic [DATA_WIDTH-1:0]  dout2
`ifdef DEMUX_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0] beats1,
  output logic [STATS_WIDTH-1:0] beats2,
  output logic [STATS_WIDTH-1:0] stall_cnt
`endif
);

  logic full1_s;
  logic full2_s;
  logic empty1_s;
  logic empty2_s;
  logic push1_s;
  logic push2_s;
  logic pop1_s;
  logic pop2_s;

  // Steering: in_ready depends only on sel and the selected FIFO's fullness.
  always_comb begin
    in_ready = 1'b0;
    push1_s  = 1'b0;
    push2_s  = 1'b0;
    case (port_e'(sel))
      PORT1: begin
        in_ready = ~full1_s;
        push1_s  = in_valid & ~full1_s;
      end
      PORT2: begin
        in_ready = ~full2_s;
        push2_s  = in_valid & ~full2_s;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign out1_valid = ~empty1_s;
  assign out2_valid = ~empty2_s;
  assign pop1_s     = out1_valid & out1_ready;
  assign pop2_s     = out2_valid & out2_ready;

  demux_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push1_s),
    .din   (din),
    .pop   (pop1_s),
    .full  (full1_s),
    .empty (empty1_s),
    .head  (dout1)
  );

  demux_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo2 (
    .clk   (clk),
    .rst   (rst),
    .push  (push2_s),
    .din   (din),
    .pop   (pop2_s),
    .full  (full2_s),
    .empty (empty2_s),
    .head  (dout2)
  );

`ifdef DEMUX_STATS_EN
  logic [STATS_WIDTH-1:0] beats1_r;
  logic [STATS_WIDTH-1:0] beats2_r;
  logic [STATS_WIDTH-1:0] stall_cnt_r;

  // Pop counters wrap; the stall counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      beats1_r    <= {STATS_WIDTH{1'b0}};
      beats2_r    <= {STATS_WIDTH{1'b0}};
      stall_cnt_r <= {STATS_WIDTH{1'b0}};
    end else begin
      if (pop1_s) begin
        beats1_r <= beats1_r + STATS_WIDTH'(1);
      end
      if (pop2_s) begin
        beats2_r <= beats2_r + STATS_WIDTH'(1);
      end
      if (in_valid && !in_ready) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end
    end
  end

  assign beats1    = beats1_r;
  assign beats2    = beats2_r;
  assign stall_cnt = stall_cnt_r;
`endif

endmodule
